// File: rtl/ifm_pkg.sv
// Shared definitions for the ingress FIFO writer and the egress reader.
// It holds the FIFO word layout and the reader's state encodings.
package ifm_pkg;

  localparam int C_DATA_W    = 64;
  localparam int C_KEEP_W    = 8;
  localparam int C_FIFO_W    = 73;
  localparam int C_TLAST_BIT = 72;
  localparam int C_TKEEP_HI  = 71;
  localparam int C_TKEEP_LO  = 64;

  localparam logic [1:0] S_IDLE = 2'h0;
  localparam logic [1:0] S_SEND = 2'h1;
  localparam logic [1:0] S_DROP = 2'h2;

  // The bit order matches the data FIFO word: {tlast, tkeep, tdata}.
  typedef struct packed {
    logic                tlast;
    logic [C_KEEP_W-1:0] tkeep;
    logic [C_DATA_W-1:0] tdata;
  } ifm_word_t;

endpackage

// File: rtl/ifm_axis_reg.sv
// One-deep AXI-Stream register slice. An input word can load in the same
// edge that the slice's current word drains.
module ifm_axis_reg #(
  parameter int W = 73
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_ready
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Handshake: a word moves on an edge where valid && ready. The upstream side
  // asserts i_valid only while o_ready=1. o_data is held stable while
  // o_valid=1 and i_ready=0.
  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_valid) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifm_out_fsm.sv
// Egress reader for the ingress FIFO pair. Each info entry selects one frame.
// A good frame is forwarded to m_axis and a bad frame is discarded; both are counted.
module ifm_out_fsm
  import ifm_pkg::*;
#(
  parameter int C_CNT_WIDTH = 32
) (
  input  logic                   rx_clk,
  input  logic                   rx_reset,
  input  logic [C_FIFO_W-1:0]    data_fifo_rdata,
  input  logic                   data_fifo_empty,
  output logic                   data_fifo_rden,
  input  logic                   info_fifo_rdata,
  input  logic                   info_fifo_empty,
  output logic                   info_fifo_rden,
  output logic [C_DATA_W-1:0]    m_axis_tdata,
  output logic [C_KEEP_W-1:0]    m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [C_CNT_WIDTH-1:0] good_frame_cnt,
  output logic [C_CNT_WIDTH-1:0] drop_frame_cnt,
  output logic [1:0]             dbg_state
);

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic                   w_info_pop;
  logic                   w_data_pop;
  logic                   w_send_pop;
  logic                   w_pop_last;
  logic                   w_reg_ready;
  logic [C_CNT_WIDTH-1:0] r_good_cnt;
  logic [C_CNT_WIDTH-1:0] r_drop_cnt;
  ifm_word_t              w_out;

  // The pops are gated by reset so that they are 0 during reset, even when a FIFO is not empty.
  assign w_info_pop = !rx_reset && (r_state == S_IDLE) && !info_fifo_empty;
  assign w_send_pop = !rx_reset && (r_state == S_SEND) && !data_fifo_empty && w_reg_ready;
  assign w_data_pop = w_send_pop ||
                      (!rx_reset && (r_state == S_DROP) && !data_fifo_empty);
  assign w_pop_last = data_fifo_rdata[C_TLAST_BIT];

  assign info_fifo_rden = w_info_pop;
  assign data_fifo_rden = w_data_pop;
  assign dbg_state      = r_state;
  assign good_frame_cnt = r_good_cnt;
  assign drop_frame_cnt = r_drop_cnt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_info_pop) w_state_nxt = info_fifo_rdata ? S_SEND : S_DROP;
      S_SEND:  if (w_data_pop && w_pop_last) w_state_nxt = S_IDLE;
      S_DROP:  if (w_data_pop && w_pop_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge rx_clk or posedge rx_reset) begin
    if (rx_reset) begin
      r_state    <= S_IDLE;
      r_good_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_data_pop && w_pop_last && (r_state == S_SEND)) r_good_cnt <= r_good_cnt + 1'b1;
      if (w_data_pop && w_pop_last && (r_state == S_DROP)) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  ifm_axis_reg #(
    .W (C_FIFO_W)
  ) u_out_reg (
    .i_clk   (rx_clk),
    .i_reset (rx_reset),
    .i_valid (w_send_pop),
    .i_data  (data_fifo_rdata),
    .o_ready (w_reg_ready),
    .o_valid (m_axis_tvalid),
    .o_data  (w_out),
    .i_ready (m_axis_tready)
  );

  assign m_axis_tdata = w_out.tdata;
  assign m_axis_tkeep = w_out.tkeep;
  assign m_axis_tlast = w_out.tlast;

endmodule
